keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display path: scans a 4x4 active-low key matrix, debounces it and reports one event per key press.
- Drives one active-low column at a time, in the same way the display drives anodes.
- Samples the row lines, debounces over full column periods, and emits a one-cycle KeyValid pulse with a 4-bit KeyCode.
- Feeds the alarm/time-set logic.

Parameters:
- CLK_DIV, 62500, Clock cycles per column step (100 MHz / 62500 = 1600 Hz); minimum 2.
- DEBOUNCE, 4, consecutive matching column samples required to accept a press or a release; minimum 1.

Ports:
- Clock  in  1  system clock; all logic rising-edge.
- resetSW  in  1  one clock; reset is asynchronous and active-low (resetSW=0 resets).
- ROW  in  4  matrix row lines, active-low, asynchronous to Clock.
- COL  out  4  column drive, active-low one-hot.
- KeyCode  out  4  code of last accepted key = rowIdx*4 + colIdx.
- KeyValid  out  1  one-cycle pulse when a press is accepted.
- KeyHeld  out  1  high from press acceptance until release is accepted.

Behaviour:
- Reset values: COL=4'b1110 (colIdx=0), KeyCode=0, KeyValid=0, KeyHeld=0, state SCAN, prescaler=0, debounce counter=0, synchronizer=4'b1111.
- ROW passes through a 2-flop synchronizer (rowSync) before any use. Its reset value is all ones.
- Prescaler counts 0..CLK_DIV-1 and wraps. tick is high for one cycle when prescaler = CLK_DIV-1.
- Sampling: all state decisions are made only on tick, using rowSync. Each column is therefore driven for exactly CLK_DIV cycles before its sample.
- COL = ~(1 << colIdx) at all times. colIdx is 2 bits and wraps 3->0.
- State SCAN, on tick:
  - rowSync = 1111: colIdx++.
  - rowSync has exactly one zero: latch candidate row pattern, rowIdx and colIdx; set cnt=1. If DEBOUNCE=1, accept immediately (see below). Otherwise go to DEBOUNCE; colIdx frozen.
  - rowSync has two or more zeros (ghost or multi-key): ignore and colIdx++.
- State DEBOUNCE, on tick:
  - rowSync equals the candidate pattern: cnt++.
  - When cnt reaches DEBOUNCE, accept: in the next cycle KeyCode=rowIdx*4+colIdx, KeyValid=1 for exactly one cycle, KeyHeld=1; go to HELD with cnt=0.
  - Any mismatch: cnt=0, colIdx++, return to SCAN. No outputs change.
- State HELD, colIdx frozen, on tick:
  - rowSync = 1111: cnt++; otherwise cnt=0.
  - When cnt reaches DEBOUNCE: KeyHeld=0, cnt=0, colIdx++, go to SCAN.
- KeyCode holds its value until the next accepted press. It is not cleared on release.
- Latency: if ROW is stable from before a column's sample, KeyValid rises in the cycle after the DEBOUNCE-th consecutive matching tick.
- Simultaneous keys while HELD:
  - Keys in other columns are invisible (column frozen).
  - A second key in the same column keeps rowSync != 1111, so release is not accepted. No new KeyValid is generated.
- Reset mid-operation: outputs clear immediately, asynchronously. A key still held after reset deasserts is detected as a new press and produces KeyValid again.
- No KeyValid is ever generated without a full debounce. At most one KeyValid per press/release cycle.

Test Plan:
All scenarios use CLK_DIV=4, DEBOUNCE=3.
1. Reset asserted, then released with ROW=1111 -> outputs at reset values. COL cycles 1110,1101,1011,0111,1110, changing every 4 clocks.
2. Hold key row1/col2 (ROW=1101 whenever COL=1011) -> COL freezes at 1011. After 3 matching ticks, exactly one KeyValid pulse, KeyCode=6, KeyHeld=1.
3. Same key active for only 2 column samples, then released -> no KeyValid, KeyHeld stays 0, scanning resumes from COL=0111.
4. After scenario 2, release (ROW=1111) -> KeyHeld falls after 3 ticks, KeyCode stays 6, scanning resumes. Press row3/col0 -> one pulse with KeyCode=12.
5. Rows 0 and 3 both low in column 1 (ROW=0110 when COL=1101) -> no KeyValid; column keeps advancing.
6. resetSW=0 while HELD with key row2/col3 still pressed -> COL=1110 and KeyHeld=0 immediately. After reset release, exactly one new KeyValid with KeyCode=11.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner: drives one column at a time, debounces the
// row lines over whole column periods and reports one event per key press.
module keypad_scanner #(
  parameter int CLK_DIV  = 62500,
  parameter int DEBOUNCE = 4
) (
  input  logic       Clock,
  input  logic       resetSW,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KeyCode,
  output logic       KeyValid,
  output logic       KeyHeld
);

  localparam int PRE_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD
  } state_t;

  logic [3:0]       row_meta, row_sync;
  logic [PRE_W-1:0] prescaler;
  logic             tick;

  state_t           state, state_nxt;
  logic [1:0]       col_idx, col_idx_nxt;
  logic [1:0]       row_idx, row_idx_nxt;
  logic [1:0]       row_enc;
  logic [3:0]       cand, cand_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic [3:0]       key_code_nxt;
  logic             key_valid_nxt, key_held_nxt;

  // ROW is asynchronous to Clock; nothing downstream looks at it before two flops.
  // NOTE: every flop uses <= so all registers update from pre-edge values.
  always_ff @(posedge Clock or negedge resetSW) begin
    if (!resetSW) begin
      row_meta  <= 4'hF;
      row_sync  <= 4'hF;
      prescaler <= '0;
    end else begin
      row_meta  <= ROW;
      row_sync  <= row_meta;
      prescaler <= tick ? '0 : prescaler + 1'b1;
    end
  end

  assign tick = (prescaler == PRE_W'(CLK_DIV - 1));
  assign COL  = ~(4'b0001 << col_idx);

  always_comb begin
    row_enc = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row_sync[i]) row_enc = 2'(i);
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    state_nxt     = state;
    col_idx_nxt   = col_idx;
    row_idx_nxt   = row_idx;
    cand_nxt      = cand;
    cnt_nxt       = cnt;
    key_code_nxt  = KeyCode;
    key_held_nxt  = KeyHeld;
    key_valid_nxt = 1'b0;

    if (tick) begin
      unique case (state)
        S_SCAN: begin
          if (row_sync == 4'hF) begin
            col_idx_nxt = col_idx + 1'b1;
          end else if ($countones(~row_sync) == 1) begin
            cand_nxt    = row_sync;
            row_idx_nxt = row_enc;
            if (DEBOUNCE == 1) begin
              key_code_nxt  = {row_enc, col_idx};
              key_valid_nxt = 1'b1;
              key_held_nxt  = 1'b1;
              cnt_nxt       = '0;
              state_nxt     = S_HELD;
            end else begin
              cnt_nxt   = CNT_W'(1);
              state_nxt = S_DEBOUNCE;
            end
          end else begin
            // Two or more rows low in one column is a ghost or multi-key: skip it.
            col_idx_nxt = col_idx + 1'b1;
          end
        end

        S_DEBOUNCE: begin
          if (row_sync == cand) begin
            if (cnt_inc == CNT_W'(DEBOUNCE)) begin
              key_code_nxt  = {row_idx, col_idx};
              key_valid_nxt = 1'b1;
              key_held_nxt  = 1'b1;
              cnt_nxt       = '0;
              state_nxt     = S_HELD;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt     = '0;
            col_idx_nxt = col_idx + 1'b1;
            state_nxt   = S_SCAN;
          end
        end

        S_HELD: begin
          if (row_sync == 4'hF) begin
            if (cnt_inc == CNT_W'(DEBOUNCE)) begin
              key_held_nxt = 1'b0;
              cnt_nxt      = '0;
              col_idx_nxt  = col_idx + 1'b1;
              state_nxt    = S_SCAN;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else begin
            cnt_nxt = '0;
          end
        end

        default: state_nxt = S_SCAN;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge resetSW) begin
    if (!resetSW) begin
      state    <= S_SCAN;
      col_idx  <= 2'd0;
      row_idx  <= 2'd0;
      cand     <= 4'hF;
      cnt      <= '0;
      KeyCode  <= 4'd0;
      KeyValid <= 1'b0;
      KeyHeld  <= 1'b0;
    end else begin
      state    <= state_nxt;
      col_idx  <= col_idx_nxt;
      row_idx  <= row_idx_nxt;
      cand     <= cand_nxt;
      cnt      <= cnt_nxt;
      KeyCode  <= key_code_nxt;
      KeyValid <= key_valid_nxt;
      KeyHeld  <= key_held_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives ROW from COL, a scoreboard
// queue holds expected KeyCodes and a forked monitor checks every KeyValid pulse.
module tb_keypad_scanner;

  localparam int CLK_DIV  = 4;
  localparam int DEBOUNCE = 3;

  logic       Clock;
  logic       resetSW;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] KeyCode;
  logic       KeyValid;
  logic       KeyHeld;

  logic [15:0] keys;   // bit index = row*4 + col
  logic [3:0]  exp_q[$];
  int          checks;
  int          failures;

  keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .Clock   (Clock),
    .resetSW (resetSW),
    .ROW     (ROW),
    .COL     (COL),
    .KeyCode (KeyCode),
    .KeyValid(KeyValid),
    .KeyHeld (KeyHeld)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // A row reads low when any pressed key on it sits in a driven (low) column.
  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (|(keys[r*4 +: 4] & ~COL)) ROW[r] = 1'b0;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge Clock);
      if (resetSW && KeyValid) begin
        if (exp_q.size() == 0) check("spurious_keyvalid", {7'd0, KeyValid}, 8'd0);
        else                   check("keycode_on_valid", {4'd0, KeyCode}, {4'd0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic wait_held(input logic val, input int budget, input string name);
    int n = 0;
    while (KeyHeld !== val && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check(name, {7'd0, KeyHeld}, {7'd0, val});
  endtask

  task automatic wait_col(input logic [3:0] target, input int budget, input string name);
    int n = 0;
    while (COL !== target && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check(name, {4'd0, COL}, {4'd0, target});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    keys     = '0;
    resetSW  = 1'b0;
    fork
      monitor();
    join_none

    // 1: reset values and free-running column scan
    repeat (3) @(negedge Clock);
    check("rst_col", {4'd0, COL}, 8'h0E);
    check("rst_keycode", {4'd0, KeyCode}, 8'h00);
    check("rst_keyvalid", {7'd0, KeyValid}, 8'h00);
    check("rst_keyheld", {7'd0, KeyHeld}, 8'h00);
    resetSW = 1'b1;
    begin
      logic [3:0] scan_seq [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
      repeat (2) @(negedge Clock);
      for (int i = 0; i < 5; i++) begin
        check("scan_col", {4'd0, COL}, {4'd0, scan_seq[i]});
        repeat (4) @(negedge Clock);
      end
    end

    // 3: key 6 seen for only two column samples, then released
    wait_col(4'b0111, 40, "glitch_wait_col3");
    keys[6] = 1'b1;
    wait_col(4'b1011, 40, "glitch_wait_col2");
    repeat (9) @(negedge Clock);
    keys = '0;
    repeat (3) @(negedge Clock);
    check("glitch_col_resume", {4'd0, COL}, 8'h07);
    check("glitch_no_held", {7'd0, KeyHeld}, 8'h00);

    // 2: key row1/col2 held
    keys[6] = 1'b1;
    exp_q.push_back(4'd6);
    wait_held(1'b1, 200, "press6_held");
    check("press6_col_frozen", {4'd0, COL}, 8'h0B);
    check("press6_keycode", {4'd0, KeyCode}, 8'h06);
    repeat (20) @(negedge Clock);
    check("press6_still_frozen", {4'd0, COL}, 8'h0B);

    // 4: release, then key row3/col0
    keys = '0;
    wait_held(1'b0, 200, "release6_held");
    check("release6_keycode_kept", {4'd0, KeyCode}, 8'h06);
    check("release6_col_next", {4'd0, COL}, 8'h07);
    keys[12] = 1'b1;
    exp_q.push_back(4'd12);
    wait_held(1'b1, 200, "press12_held");
    check("press12_col", {4'd0, COL}, 8'h0E);
    keys = '0;
    wait_held(1'b0, 200, "release12_held");

    // 5: rows 0 and 3 together in column 1 are ignored
    keys[1]  = 1'b1;
    keys[13] = 1'b1;
    wait_col(4'b1101, 40, "ghost_wait_col1");
    wait_col(4'b1011, 10, "ghost_col_advances");
    repeat (40) @(negedge Clock);
    check("ghost_no_held", {7'd0, KeyHeld}, 8'h00);
    keys = '0;

    // 6: reset while key row2/col3 is held, key still down afterwards
    keys[11] = 1'b1;
    exp_q.push_back(4'd11);
    wait_held(1'b1, 200, "press11_held");
    check("press11_keycode", {4'd0, KeyCode}, 8'h0B);
    @(negedge Clock);
    resetSW = 1'b0;
    #1;
    check("midrst_col", {4'd0, COL}, 8'h0E);
    check("midrst_held", {7'd0, KeyHeld}, 8'h00);
    check("midrst_keycode", {4'd0, KeyCode}, 8'h00);
    @(negedge Clock);
    resetSW = 1'b1;
    exp_q.push_back(4'd11);
    wait_held(1'b1, 200, "repress11_held");
    check("repress11_keycode", {4'd0, KeyCode}, 8'h0B);
    keys = '0;
    wait_held(1'b0, 200, "release11_held");

    repeat (10) @(negedge Clock);
    check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
